// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, colour helpers, coordinate type and
// the move_requester state encoding. Also used by board_validator's piece
// decoding, so the codes here must stay in step with it.
package chess_pkg;

  localparam logic [3:0] W_ROOK   = 4'd0;
  localparam logic [3:0] W_KNIGHT = 4'd1;
  localparam logic [3:0] W_BISHOP = 4'd2;
  localparam logic [3:0] W_QUEEN  = 4'd3;
  localparam logic [3:0] W_KING   = 4'd4;
  localparam logic [3:0] W_PAWN   = 4'd5;
  localparam logic [3:0] B_ROOK   = 4'd6;
  localparam logic [3:0] B_KNIGHT = 4'd7;
  localparam logic [3:0] B_BISHOP = 4'd8;
  localparam logic [3:0] B_QUEEN  = 4'd9;
  localparam logic [3:0] B_KING   = 4'd10;
  localparam logic [3:0] B_PAWN   = 4'd11;
  localparam logic [3:0] EMPTY    = 4'd15;

  typedef logic [2:0] coord_t;

  // state    | meaning
  // S_IDLE   | nothing selected
  // S_SRC    | source square held, waiting for destination
  // S_REQ    | request strobe to validator (one cycle)
  // S_WAIT   | waiting for validator verdict, timeout running
  // S_WR_DST | writing moved piece to destination
  // S_WR_SRC | clearing source square, turn flips
  typedef enum logic [2:0] {
    S_IDLE,
    S_SRC,
    S_REQ,
    S_WAIT,
    S_WR_DST,
    S_WR_SRC
  } mr_state_e;

  // Codes 12-14 are unused and count as empty, so they are neither colour.
  function automatic logic is_white(input logic [3:0] p);
    return p <= W_PAWN;
  endfunction

  function automatic logic is_black(input logic [3:0] p);
    return (p >= B_ROOK) && (p <= B_PAWN);
  endfunction

endpackage

// File: rtl/move_requester.sv
// move_requester: initiator side of the move-check handshake.
// Collects source/destination selections from the cursor, issues a one-cycle
// request to board_validator, waits (with timeout) for its verdict, then on
// acceptance writes destination and clears source over two cycles and flips
// the turn.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cur_x, cur_y, sel_pulse      cursor position and select strobe
//   board_in[y][x]               current board contents
//   req_*                        request to validator (req_valid strobe)
//   rsp_valid_move/output        validator verdict / verdict-ready
//   wr_en, wr_x, wr_y, wr_piece  board write port
//   white_turn, sel_active, sel_x, sel_y   game/selection status
//   busy, move_done, move_rejected, err_timeout   status and event pulses
// All outputs are registered; each output is set on the edge that enters the
// state it belongs to, so e.g. wr_en is high exactly while in the write states.
module move_requester
  import chess_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             cur_x,
  input  logic [2:0]             cur_y,
  input  logic                   sel_pulse,
  input  logic [7:0][7:0][3:0]   board_in,
  output logic [2:0]             req_old_x,
  output logic [2:0]             req_old_y,
  output logic [2:0]             req_new_x,
  output logic [2:0]             req_new_y,
  output logic [3:0]             req_piece_type,
  output logic                   req_valid,
  input  logic                   rsp_valid_move,
  input  logic                   rsp_valid_output,
  output logic                   wr_en,
  output logic [2:0]             wr_x,
  output logic [2:0]             wr_y,
  output logic [3:0]             wr_piece,
  output logic                   white_turn,
  output logic                   sel_active,
  output logic [2:0]             sel_x,
  output logic [2:0]             sel_y,
  output logic                   busy,
  output logic                   move_done,
  output logic                   move_rejected,
  output logic                   err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mr_state_e        state_q;
  logic [3:0]       piece_q;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic [3:0]       cur_piece;
  logic             cur_own;
  logic             cur_is_src;

  assign cur_piece  = board_in[cur_y][cur_x];
  assign cur_own    = white_turn ? is_white(cur_piece) : is_black(cur_piece);
  assign cur_is_src = (cur_x == sel_x) && (cur_y == sel_y);
  // Timeout is judged on the incremented value so err_timeout lands exactly
  // TIMEOUT_CYCLES cycles after the req_valid cycle.
  assign timer_d    = timer_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      piece_q        <= '0;
      timer_q        <= '0;
      req_old_x      <= '0;
      req_old_y      <= '0;
      req_new_x      <= '0;
      req_new_y      <= '0;
      req_piece_type <= '0;
      req_valid      <= 1'b0;
      wr_en          <= 1'b0;
      wr_x           <= '0;
      wr_y           <= '0;
      wr_piece       <= '0;
      white_turn     <= 1'b1;
      sel_active     <= 1'b0;
      sel_x          <= '0;
      sel_y          <= '0;
      busy           <= 1'b0;
      move_done      <= 1'b0;
      move_rejected  <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      req_valid     <= 1'b0;
      wr_en         <= 1'b0;
      move_done     <= 1'b0;
      move_rejected <= 1'b0;
      err_timeout   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (sel_pulse && cur_own) begin
            sel_x      <= cur_x;
            sel_y      <= cur_y;
            piece_q    <= cur_piece;
            sel_active <= 1'b1;
            state_q    <= S_SRC;
          end
        end

        S_SRC: begin
          if (sel_pulse) begin
            if (cur_is_src) begin
              sel_active <= 1'b0;
              state_q    <= S_IDLE;
            end else if (cur_own) begin
              sel_x   <= cur_x;
              sel_y   <= cur_y;
              piece_q <= cur_piece;
            end else begin
              // Empty or opponent square: a capture is just a normal move.
              req_old_x      <= sel_x;
              req_old_y      <= sel_y;
              req_new_x      <= cur_x;
              req_new_y      <= cur_y;
              req_piece_type <= piece_q;
              req_valid      <= 1'b1;
              busy           <= 1'b1;
              state_q        <= S_REQ;
            end
          end
        end

        S_REQ: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          timer_q <= timer_d;
          // A verdict takes priority over a timeout in the same cycle.
          if (rsp_valid_output) begin
            if (rsp_valid_move) begin
              wr_en    <= 1'b1;
              wr_x     <= req_new_x;
              wr_y     <= req_new_y;
              wr_piece <= piece_q;
              state_q  <= S_WR_DST;
            end else begin
              move_rejected <= 1'b1;
              sel_active    <= 1'b0;
              busy          <= 1'b0;
              state_q       <= S_IDLE;
            end
          end else if (timer_d == TC_LAST) begin
            err_timeout <= 1'b1;
            sel_active  <= 1'b0;
            busy        <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        S_WR_DST: begin
          wr_en      <= 1'b1;
          wr_x       <= sel_x;
          wr_y       <= sel_y;
          wr_piece   <= EMPTY;
          move_done  <= 1'b1;
          white_turn <= ~white_turn;
          sel_active <= 1'b0;
          state_q    <= S_WR_SRC;
        end

        S_WR_SRC: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy       <= 1'b0;
          sel_active <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_requester.sv
module tb_move_requester;
  import chess_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [2:0]           cur_x = '0;
  logic [2:0]           cur_y = '0;
  logic                 sel_pulse = 1'b0;
  logic [7:0][7:0][3:0] board;
  logic [2:0]           req_old_x, req_old_y, req_new_x, req_new_y;
  logic [3:0]           req_piece_type;
  logic                 req_valid;
  logic                 rsp_valid_move = 1'b0;
  logic                 rsp_valid_output = 1'b0;
  logic                 wr_en;
  logic [2:0]           wr_x, wr_y;
  logic [3:0]           wr_piece;
  logic                 white_turn, sel_active;
  logic [2:0]           sel_x, sel_y;
  logic                 busy, move_done, move_rejected, err_timeout;

  move_requester #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n), .cur_x(cur_x), .cur_y(cur_y),
    .sel_pulse(sel_pulse), .board_in(board),
    .req_old_x(req_old_x), .req_old_y(req_old_y),
    .req_new_x(req_new_x), .req_new_y(req_new_y),
    .req_piece_type(req_piece_type), .req_valid(req_valid),
    .rsp_valid_move(rsp_valid_move), .rsp_valid_output(rsp_valid_output),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_piece(wr_piece),
    .white_turn(white_turn), .sel_active(sel_active),
    .sel_x(sel_x), .sel_y(sel_y), .busy(busy), .move_done(move_done),
    .move_rejected(move_rejected), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_REQ, EV_WR, EV_DONE, EV_REJ, EV_TMO} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [2:0] ax, ay, bx, by;
    logic [3:0] p;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic void push_ev(ev_kind_e k, logic [2:0] ax, logic [2:0] ay,
                                  logic [2:0] bx, logic [2:0] by, logic [3:0] p);
    ev_t e;
    e.kind = k; e.ax = ax; e.ay = ay; e.bx = bx; e.by = by; e.p = p;
    exp_q.push_back(e);
  endfunction

  // Scoreboard: every output event is matched, in order, against the queue.
  always @(negedge clk) begin
    ev_t e;
    if (reset_n) begin
      if (req_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL sb_req: unexpected req_valid");
        end else begin
          e = exp_q.pop_front();
          if (e.kind != EV_REQ || {req_old_x, req_old_y, req_new_x, req_new_y, req_piece_type}
              !== {e.ax, e.ay, e.bx, e.by, e.p}) begin
            n_err++;
            $display("FAIL sb_req: got old=(%0d,%0d) new=(%0d,%0d) p=%0d, expected kind=%0d old=(%0d,%0d) new=(%0d,%0d) p=%0d",
                     req_old_x, req_old_y, req_new_x, req_new_y, req_piece_type,
                     e.kind, e.ax, e.ay, e.bx, e.by, e.p);
          end
        end
      end
      if (wr_en) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL sb_wr: unexpected wr_en (%0d,%0d)=%0d", wr_x, wr_y, wr_piece);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != EV_WR || {wr_x, wr_y, wr_piece} !== {e.ax, e.ay, e.p}) begin
            n_err++;
            $display("FAIL sb_wr: got (%0d,%0d)=%0d, expected kind=%0d (%0d,%0d)=%0d",
                     wr_x, wr_y, wr_piece, e.kind, e.ax, e.ay, e.p);
          end
        end
      end
      if (move_done) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL sb_done: unexpected move_done");
        end else begin
          e = exp_q.pop_front();
          if (e.kind != EV_DONE) begin
            n_err++; $display("FAIL sb_done: got move_done, expected kind=%0d", e.kind);
          end
        end
      end
      if (move_rejected) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL sb_rej: unexpected move_rejected");
        end else begin
          e = exp_q.pop_front();
          if (e.kind != EV_REJ) begin
            n_err++; $display("FAIL sb_rej: got move_rejected, expected kind=%0d", e.kind);
          end
        end
      end
      if (err_timeout) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL sb_tmo: unexpected err_timeout");
        end else begin
          e = exp_q.pop_front();
          if (e.kind != EV_TMO) begin
            n_err++; $display("FAIL sb_tmo: got err_timeout, expected kind=%0d", e.kind);
          end
        end
      end
    end
  end

  task automatic init_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        board[y][x] = EMPTY;
    board[6][4] = W_PAWN;
    board[7][1] = W_KNIGHT;
    board[0][1] = B_KNIGHT;
    board[1][3] = B_PAWN;
    board[3][3] = W_BISHOP;
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic sel(input logic [2:0] x, input logic [2:0] y);
    cur_x = x; cur_y = y; sel_pulse = 1'b1;
    @(negedge clk);
    sel_pulse = 1'b0;
  endtask

  task automatic rsp(input logic v);
    rsp_valid_output = 1'b1; rsp_valid_move = v;
    @(negedge clk);
    rsp_valid_output = 1'b0; rsp_valid_move = 1'b0;
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1 reset_n = 1'b1;
    init_board();
    @(negedge clk);
  endtask

  task automatic check_queue_empty(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s_pending: %0d events outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    init_board();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({req_old_x, req_old_y, req_new_x, req_new_y, req_piece_type, req_valid, wr_en, wr_x, wr_y,
         wr_piece, sel_active, sel_x, sel_y, busy, move_done, move_rejected, err_timeout} !== '0) begin
      n_err++; $display("FAIL reset_zero: some output nonzero during reset");
    end
    n_vec++;
    if (white_turn !== 1'b1) begin
      n_err++; $display("FAIL reset_turn: white_turn=%b expected 1", white_turn);
    end
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_move();
    push_ev(EV_REQ, 4, 6, 4, 4, W_PAWN);
    sel(4, 6);
    n_vec++;
    if ({sel_active, sel_x, sel_y} !== {1'b1, 3'd4, 3'd6}) begin
      n_err++; $display("FAIL basic_src: sel=%b (%0d,%0d) expected 1 (4,6)", sel_active, sel_x, sel_y);
    end
    sel(4, 4);
    n_vec++;
    if (req_valid !== 1'b1) begin
      n_err++; $display("FAIL basic_req_lat: req_valid=%b expected 1", req_valid);
    end
    @(negedge clk);
    n_vec++;
    if (req_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_req_once: req_valid=%b busy=%b expected 0 1", req_valid, busy);
    end
    repeat (2) @(negedge clk);
    push_ev(EV_WR, 4, 4, 0, 0, W_PAWN);
    push_ev(EV_WR, 4, 6, 0, 0, EMPTY);
    push_ev(EV_DONE, 0, 0, 0, 0, 0);
    rsp(1'b1);
    n_vec++;
    if ({wr_en, wr_x, wr_y, wr_piece} !== {1'b1, 3'd4, 3'd4, W_PAWN}) begin
      n_err++; $display("FAIL basic_wr_dst: wr=%b (%0d,%0d)=%0d expected 1 (4,4)=5", wr_en, wr_x, wr_y, wr_piece);
    end
    @(negedge clk);
    n_vec++;
    if ({move_done, wr_en, white_turn} !== 3'b110) begin
      n_err++; $display("FAIL basic_done: done=%b wr_en=%b turn=%b expected 1 1 0", move_done, wr_en, white_turn);
    end
    @(negedge clk);
    n_vec++;
    if ({wr_en, busy, sel_active, white_turn} !== 4'b0000) begin
      n_err++; $display("FAIL basic_after: wr_en=%b busy=%b sel=%b turn=%b expected 0000", wr_en, busy, sel_active, white_turn);
    end
    board[4][4] = W_PAWN; board[6][4] = EMPTY;
    check_queue_empty("basic");
  endtask

  // Black to move: a white piece is not selectable; black pawn captures bishop.
  task automatic test_back_to_back();
    sel(4, 4);
    n_vec++;
    if (sel_active !== 1'b0) begin
      n_err++; $display("FAIL b2b_wrong_side: sel_active=%b expected 0", sel_active);
    end
    push_ev(EV_REQ, 3, 1, 3, 3, B_PAWN);
    sel(3, 1);
    sel(3, 3);
    @(negedge clk);
    push_ev(EV_WR, 3, 3, 0, 0, B_PAWN);
    push_ev(EV_WR, 3, 1, 0, 0, EMPTY);
    push_ev(EV_DONE, 0, 0, 0, 0, 0);
    rsp(1'b1);
    repeat (2) @(negedge clk);
    n_vec++;
    if (white_turn !== 1'b1) begin
      n_err++; $display("FAIL b2b_turn: white_turn=%b expected 1", white_turn);
    end
    board[3][3] = B_PAWN; board[1][3] = EMPTY;
    check_queue_empty("b2b");
  endtask

  task automatic test_reject();
    push_ev(EV_REQ, 4, 6, 4, 4, W_PAWN);
    push_ev(EV_REJ, 0, 0, 0, 0, 0);
    sel(4, 6);
    sel(4, 4);
    @(negedge clk);
    sel(1, 7);
    n_vec++;
    if ({sel_x, sel_y} !== {3'd4, 3'd6}) begin
      n_err++; $display("FAIL rej_drop_sel: sel=(%0d,%0d) expected (4,6)", sel_x, sel_y);
    end
    rsp(1'b0);
    n_vec++;
    if ({move_rejected, wr_en, sel_active, white_turn, busy} !== 5'b10010) begin
      n_err++; $display("FAIL rej_flags: rej=%b wr=%b sel=%b turn=%b busy=%b expected 1 0 0 1 0",
                        move_rejected, wr_en, sel_active, white_turn, busy);
    end
    repeat (2) @(negedge clk);
    check_queue_empty("reject");
  endtask

  task automatic test_wrong_color();
    sel(1, 0);
    n_vec++;
    if ({sel_active, busy} !== 2'b00) begin
      n_err++; $display("FAIL wrong_color: sel=%b busy=%b expected 0 0", sel_active, busy);
    end
    sel(0, 3);
    n_vec++;
    if (sel_active !== 1'b0) begin
      n_err++; $display("FAIL empty_sel: sel_active=%b expected 0", sel_active);
    end
  endtask

  task automatic test_deselect();
    sel(1, 7);
    n_vec++;
    if ({sel_active, sel_x, sel_y} !== {1'b1, 3'd1, 3'd7}) begin
      n_err++; $display("FAIL desel_src: sel=%b (%0d,%0d) expected 1 (1,7)", sel_active, sel_x, sel_y);
    end
    sel(1, 7);
    repeat (3) @(negedge clk);
    n_vec++;
    if ({sel_active, busy} !== 2'b00) begin
      n_err++; $display("FAIL desel: sel=%b busy=%b expected 0 0", sel_active, busy);
    end
    check_queue_empty("deselect");
  endtask

  task automatic test_reselect();
    sel(4, 6);
    sel(1, 7);
    n_vec++;
    if ({sel_active, sel_x, sel_y, busy} !== {1'b1, 3'd1, 3'd7, 1'b0}) begin
      n_err++; $display("FAIL resel: sel=%b (%0d,%0d) busy=%b expected 1 (1,7) 0", sel_active, sel_x, sel_y, busy);
    end
    push_ev(EV_REQ, 1, 7, 2, 5, W_KNIGHT);
    push_ev(EV_REJ, 0, 0, 0, 0, 0);
    sel(2, 5);
    @(negedge clk);
    rsp(1'b0);
    @(negedge clk);
    check_queue_empty("reselect");
  endtask

  task automatic test_timeout();
    int k;
    push_ev(EV_REQ, 4, 6, 4, 5, W_PAWN);
    push_ev(EV_TMO, 0, 0, 0, 0, 0);
    sel(4, 6);
    sel(4, 5);
    k = 0;
    while (err_timeout !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k != 64) begin
      n_err++; $display("FAIL tmo_latency: err_timeout after %0d cycles, expected 64", k);
    end
    n_vec++;
    if ({sel_active, busy, wr_en} !== 3'b000) begin
      n_err++; $display("FAIL tmo_state: sel=%b busy=%b wr=%b expected 000", sel_active, busy, wr_en);
    end
    @(negedge clk);
    check_queue_empty("timeout");
  endtask

  task automatic test_timeout_race();
    push_ev(EV_REQ, 4, 6, 4, 5, W_PAWN);
    sel(4, 6);
    sel(4, 5);
    repeat (63) @(negedge clk);
    push_ev(EV_WR, 4, 5, 0, 0, W_PAWN);
    push_ev(EV_WR, 4, 6, 0, 0, EMPTY);
    push_ev(EV_DONE, 0, 0, 0, 0, 0);
    rsp(1'b1);
    n_vec++;
    if ({err_timeout, wr_en} !== 2'b01) begin
      n_err++; $display("FAIL race: err_timeout=%b wr_en=%b expected 0 1", err_timeout, wr_en);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (white_turn !== 1'b0) begin
      n_err++; $display("FAIL race_turn: white_turn=%b expected 0", white_turn);
    end
    board[5][4] = W_PAWN; board[6][4] = EMPTY;
    check_queue_empty("race");
  endtask

  task automatic test_reset_mid();
    // Black to move, reset while waiting for the validator.
    push_ev(EV_REQ, 3, 1, 3, 2, B_PAWN);
    sel(3, 1);
    sel(3, 2);
    @(negedge clk);
    #1 reset_n = 1'b0;
    exp_q.delete();
    #1;
    n_vec++;
    if ({white_turn, busy, sel_active, req_valid} !== 4'b1000) begin
      n_err++; $display("FAIL rst_wait: turn=%b busy=%b sel=%b req=%b expected 1000", white_turn, busy, sel_active, req_valid);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    rsp(1'b1);
    repeat (3) @(negedge clk);
    n_vec++;
    if ({white_turn, busy} !== 2'b10) begin
      n_err++; $display("FAIL rst_wait_after: turn=%b busy=%b expected 1 0", white_turn, busy);
    end
    // White to move, reset while the destination write is on the bus.
    push_ev(EV_REQ, 4, 5, 4, 4, W_PAWN);
    push_ev(EV_WR, 4, 4, 0, 0, W_PAWN);
    sel(4, 5);
    sel(4, 4);
    @(negedge clk);
    rsp(1'b1);
    n_vec++;
    if (wr_en !== 1'b1) begin
      n_err++; $display("FAIL rst_wr_pre: wr_en=%b expected 1", wr_en);
    end
    #1 reset_n = 1'b0;
    exp_q.delete();
    #1;
    n_vec++;
    if ({wr_en, move_done, busy, white_turn} !== 4'b0001) begin
      n_err++; $display("FAIL rst_wr: wr=%b done=%b busy=%b turn=%b expected 0001", wr_en, move_done, busy, white_turn);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({wr_en, white_turn, sel_active} !== 3'b010) begin
      n_err++; $display("FAIL rst_wr_after: wr=%b turn=%b sel=%b expected 0 1 0", wr_en, white_turn, sel_active);
    end
    check_queue_empty("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_back_to_back();
    do_reset();
    test_reject();
    test_wrong_color();
    test_deselect();
    test_reselect();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/move_requester.md
Name: move_requester

Overview:
- Initiator side of the move-check handshake.
- Captures player square selections from the cursor/select input and forms a move request (old/new coordinates plus piece type). Presents the request to board_validator and waits for its verdict.
- On acceptance, commits the move to the board register file through a two-cycle write sequence and flips the turn.
- Sits between the cursor/input logic and board_validator/board storage in game_play.

Parameters:
- TIMEOUT_CYCLES, 64, cycles to wait for validator response before aborting the request.
- CNT_W, $clog2(TIMEOUT_CYCLES)+1, timeout counter width (derived; do not override).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- cur_x  input  3  cursor column.
- cur_y  input  3  cursor row.
- sel_pulse  input  1  single-cycle select strobe (already debounced/edge-detected upstream).
- board_in  input  4 x [8][8]  current board, indexed board_in[y][x].
- req_old_x, req_old_y  output  3 each  source square to validator.
- req_new_x, req_new_y  output  3 each  destination square to validator.
- req_piece_type  output  4  piece on source square.
- req_valid  output  1  request strobe; top level drives it into validator valid_input bit 0, upper bits 0.
- rsp_valid_move  input  1  validator verdict.
- rsp_valid_output  input  1  validator verdict-ready.
- wr_en  output  1  board write enable.
- wr_x, wr_y  output  3 each  board write address.
- wr_piece  output  4  board write data.
- white_turn  output  1  1 = white to move.
- sel_active  output  1  source square currently held.
- sel_x, sel_y  output  3 each  held source square (for highlight).
- busy  output  1  high in S_REQ, S_WAIT, S_WR_DST, S_WR_SRC.
- move_done  output  1  pulse: move committed.
- move_rejected  output  1  pulse: validator returned invalid.
- err_timeout  output  1  pulse: no response within TIMEOUT_CYCLES.

Behaviour:
- Piece codes: 0-5 white (rook, knight, bishop, queen, king, pawn); 6-11 black (same order); 15 = EMPTY; 12-14 treated as EMPTY.
- "Own piece" means white code when white_turn=1, black code otherwise.
- All outputs are registered.
- Reset values: white_turn=1; every other output 0; state S_IDLE; timer 0.
- S_IDLE:
  - sel_pulse on own piece -> latch src=(cur_x,cur_y) and piece=board_in[cur_y][cur_x]; sel_active<=1; go to S_SRC.
  - sel_pulse on any other square -> ignored, no flag.
- S_SRC:
  - sel_pulse on the src square -> deselect (sel_active<=0), go to S_IDLE.
  - sel_pulse on another own piece -> re-latch src and piece, stay in S_SRC.
  - sel_pulse on any other square -> latch dst, drive req_* fields, go to S_REQ.
- S_REQ:
  - req_valid=1 for exactly one cycle (first cycle after dst select); timer cleared.
  - Go to S_WAIT.
- S_WAIT:
  - Timer increments each cycle.
  - rsp_valid_output=1 and rsp_valid_move=1 -> go to S_WR_DST.
  - rsp_valid_output=1 and rsp_valid_move=0 -> move_rejected pulse, sel_active<=0, go to S_IDLE.
  - Timer reaching TIMEOUT_CYCLES-1 with no response -> err_timeout pulse, sel_active<=0, go to S_IDLE.
  - Response and timeout in the same cycle: the response wins.
- req_old/new_x/y and req_piece_type are held stable from the S_REQ cycle until the module leaves S_WAIT.
- rsp_valid_output outside S_WAIT is ignored.
- S_WR_DST: wr_en=1, wr_x/wr_y=dst, wr_piece=latched piece; go to S_WR_SRC.
- S_WR_SRC:
  - wr_en=1, wr_x/wr_y=src, wr_piece=EMPTY.
  - move_done pulse, white_turn toggles, sel_active<=0.
  - Go to S_IDLE.
- wr_en is high only in the two write states.
- Captures are taken as a normal move. The destination write overwrites the captured piece; no separate capture logic.
- sel_pulse in S_REQ, S_WAIT, S_WR_DST or S_WR_SRC is dropped and not queued.
- Latency:
  - dst sel_pulse -> req_valid: 1 cycle.
  - Response accepted -> first wr_en: 1 cycle.
  - Response accepted -> move_done: 2 cycles.
- Reset mid-operation: immediate return to reset values. No partial board write survives beyond a cycle already committed.
- Out of scope: promotion, castling, en passant, check detection.

Decomposition:
- chess_pkg holds:
  - piece code localparams (W_ROOK..B_PAWN, EMPTY=4'd15);
  - is_white() and is_black() functions;
  - coord_t (logic [2:0]);
  - the move_requester state enum (S_IDLE, S_SRC, S_REQ, S_WAIT, S_WR_DST, S_WR_SRC).
- board_validator piece decoding shares the same package.
- Single module; no sub-module. The timeout counter is inline.

Test Plan:
- Reset, white pawn (5) at (4,6): sel (4,6), sel (4,4), validator answers valid after 3 cycles. Required response:
  - req_valid pulses once with old=(4,6), new=(4,4), piece=5;
  - wr (4,4)=5, then wr (4,6)=15;
  - move_done pulses; white_turn=0.
- Same request, validator returns valid_move=0 -> move_rejected pulse, no wr_en, white_turn stays 1, sel_active=0.
- sel on black knight (7) while white_turn=1 -> no state change, sel_active=0, no flags.
- sel (1,7) white knight, then sel (1,7) again -> sel_active returns to 0, no req_valid.
- Request issued, validator silent -> err_timeout pulses exactly 64 cycles after req_valid (TIMEOUT_CYCLES=64), state back to S_IDLE. Response arriving on the timeout cycle -> treated as a response, no err_timeout.
- reset_n asserted during S_WAIT and during S_WR_DST -> all outputs return to reset values next edge, white_turn=1, no further wr_en.
